// File: rtl/iomem_yanitlayici_pkg.sv
// Shared definitions for the iomem responder: FSM state encoding, default RAM window base,
// read value returned on error/write responses, and the wait-state LFSR constants.
package anabellek_paket;

   typedef enum logic [2:0] {
      BOSTA  = 3'd0,
      ERISIM = 3'd1,
      BEKLE  = 3'd2,
      YANIT  = 3'd3,
      BITIS  = 3'd4
   } durum_t;

   localparam logic [31:0] TABAN_VARSAYILAN = 32'h4000_0000;
   localparam logic [31:0] HATA_OKUMA       = 32'h0000_0000;

   // x^4 + x^3 + 1: feedback is the XOR of bits 3 and 2
   localparam logic [3:0]  LFSR_TOHUM  = 4'b1001;
   localparam logic [3:0]  LFSR_MUSLUK = 4'b1100;

endpackage

// File: rtl/iomem_yanitlayici_lfsr.sv
// 4-bit Fibonacci LFSR that produces 0..3 extra wait cycles per accepted request.
// Only instantiated when IOMEM_RASTGELE_BEKLEME_EN is defined.
module rastgele_bekleme_lfsr
   import anabellek_paket::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       en_i,
   output logic [1:0] ek_o
);

   logic [3:0] lfsr_q;
   logic [3:0] lfsr_d;

   always_comb begin
      lfsr_d = lfsr_q;
      if (en_i) begin
         lfsr_d = {lfsr_q[2:0], ^(lfsr_q & LFSR_MUSLUK)};
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         lfsr_q <= LFSR_TOHUM;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign ek_o = lfsr_q[1:0];

endmodule

// File: rtl/iomem_yanitlayici.sv
// iomem bus responder backed by one single-port RAM macro with fixed-latency FSM.
// Optional random wait states: define IOMEM_RASTGELE_BEKLEME_EN.
module iomem_yanitlayici
   import anabellek_paket::*;
#(
   parameter int          ADR_BIT = 9,
   parameter logic [31:0] TABAN   = TABAN_VARSAYILAN,
   parameter int          BEKLEME = 2
)
(
   input  logic               clk_i,
   input  logic               rst_i,
   // Handshake: the initiator raises iomem_valid and holds every request field until it
   // sees the one-cycle iomem_ready pulse; request fields are captured once, on acceptance.
   input  logic               iomem_valid,
   output logic               iomem_ready,
   input  logic [3:0]         iomem_wstrb,
   input  logic [31:0]        iomem_addr,
   input  logic [31:0]        iomem_wdata,
   output logic [31:0]        iomem_rdata,
   output logic               hata_o,
   output logic               mem_en_o,
   output logic [3:0]         mem_we_o,
   output logic [ADR_BIT-1:0] mem_adr_o,
   output logic [31:0]        mem_di_o,
   input  logic [31:0]        mem_do_i,
   output durum_t             durum_o
);

   durum_t      durum_q, durum_d;
   logic [31:0] adr_q, adr_d;
   logic [3:0]  wstrb_q, wstrb_d;
   logic [31:0] wdata_q, wdata_d;
   logic        icinde_q, icinde_d;
   logic [4:0]  sayac_q, sayac_d;
   logic        ilk_q, ilk_d;
   logic [31:0] okunan_q, okunan_d;
   logic        ready_q, ready_d;
   logic        hata_q, hata_d;
   logic [31:0] rdata_q, rdata_d;

   logic        kabul;
   logic        icinde_w;
   logic [32:0] adr_genis;
   logic [32:0] alt_sinir;
   logic [32:0] ust_sinir;
   logic [4:0]  bekleme_yuk;

   assign kabul = (durum_q == BOSTA) && iomem_valid;

   // Window check done one bit wider so a window ending at 4 GiB cannot wrap
   assign adr_genis = {1'b0, iomem_addr};
   assign alt_sinir = {1'b0, TABAN};
   assign ust_sinir = {1'b0, TABAN} + (33'd1 << (ADR_BIT + 2));
   assign icinde_w  = (adr_genis >= alt_sinir) && (adr_genis < ust_sinir);

`ifdef IOMEM_RASTGELE_BEKLEME_EN
   logic [1:0] ek_bekleme;

   rastgele_bekleme_lfsr u_lfsr (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .en_i  (kabul),
      .ek_o  (ek_bekleme)
   );

   assign bekleme_yuk = 5'(BEKLEME) + {3'b000, ek_bekleme};
`else
   assign bekleme_yuk = 5'(BEKLEME);
`endif

   always_comb begin
      durum_d  = durum_q;
      adr_d    = adr_q;
      wstrb_d  = wstrb_q;
      wdata_d  = wdata_q;
      icinde_d = icinde_q;
      sayac_d  = sayac_q;
      ilk_d    = ilk_q;
      okunan_d = okunan_q;
      ready_d  = 1'b0;
      hata_d   = 1'b0;
      rdata_d  = HATA_OKUMA;
      mem_en_o = 1'b0;
      mem_we_o = 4'b0000;

      unique case (durum_q)
         BOSTA: begin
            if (iomem_valid) begin
               adr_d    = iomem_addr;
               wstrb_d  = iomem_wstrb;
               wdata_d  = iomem_wdata;
               icinde_d = icinde_w;
               durum_d  = ERISIM;
            end
         end
         ERISIM: begin
            if (icinde_q) begin
               mem_en_o = 1'b1;
               mem_we_o = wstrb_q;
            end
            sayac_d = bekleme_yuk;
            ilk_d   = 1'b1;
            durum_d = BEKLE;
         end
         BEKLE: begin
            ilk_d = 1'b0;
            if (ilk_q) begin
               okunan_d = mem_do_i;
            end
            if (sayac_q == 5'd0) begin
               durum_d = YANIT;
               ready_d = 1'b1;
               hata_d  = !icinde_q;
               // With no extra wait the RAM word is still on mem_do_i this cycle
               if (icinde_q && (wstrb_q == 4'b0000)) begin
                  rdata_d = ilk_q ? mem_do_i : okunan_q;
               end
            end else begin
               sayac_d = sayac_q - 5'd1;
            end
         end
         YANIT: begin
            durum_d = BITIS;
         end
         BITIS: begin
            durum_d = BOSTA;
         end
         default: begin
            durum_d = BOSTA;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         durum_q  <= BOSTA;
         adr_q    <= 32'h0;
         wstrb_q  <= 4'h0;
         wdata_q  <= 32'h0;
         icinde_q <= 1'b0;
         sayac_q  <= 5'd0;
         ilk_q    <= 1'b0;
         okunan_q <= 32'h0;
         ready_q  <= 1'b0;
         hata_q   <= 1'b0;
         rdata_q  <= 32'h0;
      end else begin
         durum_q  <= durum_d;
         adr_q    <= adr_d;
         wstrb_q  <= wstrb_d;
         wdata_q  <= wdata_d;
         icinde_q <= icinde_d;
         sayac_q  <= sayac_d;
         ilk_q    <= ilk_d;
         okunan_q <= okunan_d;
         ready_q  <= ready_d;
         hata_q   <= hata_d;
         rdata_q  <= rdata_d;
      end
   end

   assign mem_adr_o   = ADR_BIT'((adr_q - TABAN) >> 2);
   assign mem_di_o    = wdata_q;
   assign iomem_ready = ready_q;
   assign hata_o      = hata_q;
   assign iomem_rdata = rdata_q;
   assign durum_o     = durum_q;

endmodule
